// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired sequencer and CPU_Datapath:
// instruction/condition inputs and every datapath control strobe.
interface control_sequencer_if;
    logic [31:0] IR;
    logic        CON;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, wren, IRin, Yin;
    logic        Zin, ZLowout, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CON_FF_In;
    logic [4:0]  ALUSelection;
    logic        run;

    modport master (
        input  IR, CON,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, wren, IRin, Yin,
               Zin, ZLowout, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CON_FF_In,
               ALUSelection, run
    );

    modport slave (
        output IR, CON,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, wren, IRin, Yin,
               Zin, ZLowout, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CON_FF_In,
               ALUSelection, run
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for CPU_Datapath; strobes are
// registered and computed from the state being entered.
//
// state | meaning
// IDLE  | out of reset, no strobes
// T0-T2 | instruction fetch (PC -> MAR, memory -> MDR -> IR)
// T3-T7 | execute, pattern chosen by the opcode class latched at T2
// HALT  | stopped until clr
module control_sequencer #(
    parameter bit         ILLEGAL_HALTS = 1'b0,
    parameter logic [4:0] ALU_ADD       = 5'b00001,
    parameter logic [4:0] ALU_SUB       = 5'b00010,
    parameter logic [4:0] ALU_AND       = 5'b00011,
    parameter logic [4:0] ALU_OR        = 5'b00100
) (
    input  logic               clk,
    input  logic               clr,
    control_sequencer_if.master bus
);
    typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
    typedef enum logic [2:0] {C_LD, C_LDI, C_ST, C_ALU, C_ADDI, C_BR, C_NOP, C_HALT} op_class_t;

    typedef struct packed {
        logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, mdr_read, wren, ir_in, y_in;
        logic z_in, zlow_out, gra, grb, grc, r_in, r_out, ba_out, c_out, con_ff_in;
        logic [4:0] alu_sel;
        logic run;
    } ctrl_t;

    state_t     state, state_nxt;
    op_class_t  cls_q, cls_nxt;
    logic [4:0] alu_q, alu_nxt;
    ctrl_t      ctrl_q;

    function automatic op_class_t classify(input logic [4:0] op);
        case (op)
            5'b00000:                               return C_LD;
            5'b00001:                               return C_LDI;
            5'b00010:                               return C_ST;
            5'b00011, 5'b00100, 5'b00101, 5'b00110: return C_ALU;
            5'b01100:                               return C_ADDI;
            5'b10010:                               return C_BR;
            5'b11010:                               return C_NOP;
            5'b11011:                               return C_HALT;
            default:                                return ILLEGAL_HALTS ? C_HALT : C_NOP;
        endcase
    endfunction

    function automatic logic [4:0] alu_of(input logic [4:0] op);
        case (op)
            5'b00100: return ALU_SUB;
            5'b00101: return ALU_AND;
            5'b00110: return ALU_OR;
            default:  return ALU_ADD;
        endcase
    endfunction

    // Strobe pattern for the state being entered.
    function automatic ctrl_t decode(input state_t s, input op_class_t c,
                                     input logic [4:0] alu_code, input logic con);
        ctrl_t o;
        o = '0;
        o.run = (s != IDLE) && (s != HALT);
        case (s)
            T0: begin o.pc_out = 1'b1; o.mar_in = 1'b1; o.inc_pc = 1'b1; o.z_in = 1'b1; end
            T1: begin o.zlow_out = 1'b1; o.pc_in = 1'b1; o.mdr_read = 1'b1; o.mdr_in = 1'b1; end
            T2: begin o.mdr_out = 1'b1; o.ir_in = 1'b1; end
            T3: begin
                o.y_in = 1'b1;
                if (c == C_BR) begin
                    o.gra = 1'b1; o.r_out = 1'b1; o.con_ff_in = 1'b1; o.y_in = 1'b0;
                end else if (c == C_LD || c == C_LDI || c == C_ST) begin
                    o.grb = 1'b1; o.ba_out = 1'b1;
                end else begin
                    o.grb = 1'b1; o.r_out = 1'b1;
                end
            end
            T4: begin
                if (c == C_BR) begin
                    o.pc_out = 1'b1; o.y_in = 1'b1;
                end else if (c == C_ALU) begin
                    o.grc = 1'b1; o.r_out = 1'b1; o.alu_sel = alu_code; o.z_in = 1'b1;
                end else begin
                    o.c_out = 1'b1; o.alu_sel = ALU_ADD; o.z_in = 1'b1;
                end
            end
            T5: begin
                if (c == C_BR) begin
                    o.c_out = 1'b1; o.alu_sel = ALU_ADD; o.z_in = 1'b1;
                end else if (c == C_LD || c == C_ST) begin
                    o.zlow_out = 1'b1; o.mar_in = 1'b1;
                end else begin
                    o.zlow_out = 1'b1; o.gra = 1'b1; o.r_in = 1'b1;
                end
            end
            T6: begin
                if (c == C_LD) begin
                    o.mdr_read = 1'b1; o.mdr_in = 1'b1;
                end else if (c == C_ST) begin
                    o.gra = 1'b1; o.r_out = 1'b1; o.mdr_in = 1'b1;
                end else if (con) begin
                    o.zlow_out = 1'b1; o.pc_in = 1'b1;
                end
            end
            T7: begin
                if (c == C_ST) o.wren = 1'b1;
                else begin o.mdr_out = 1'b1; o.gra = 1'b1; o.r_in = 1'b1; end
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    always_comb begin
        cls_nxt   = (state == T2) ? classify(bus.IR[31:27]) : cls_q;
        alu_nxt   = (state == T2) ? alu_of(bus.IR[31:27]) : alu_q;
        state_nxt = state;
        case (state)
            IDLE: state_nxt = T0;
            T0:   state_nxt = T1;
            T1:   state_nxt = T2;
            T2:   state_nxt = (cls_nxt == C_NOP) ? T0 : (cls_nxt == C_HALT) ? HALT : T3;
            T3:   state_nxt = T4;
            T4:   state_nxt = T5;
            T5:   state_nxt = (cls_q == C_LD || cls_q == C_ST || cls_q == C_BR) ? T6 : T0;
            T6:   state_nxt = (cls_q == C_BR) ? T0 : T7;
            T7:   state_nxt = T0;
            HALT: state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= IDLE;
            cls_q  <= C_NOP;
            alu_q  <= '0;
            ctrl_q <= '0;
        end else begin
            state  <= state_nxt;
            cls_q  <= cls_nxt;
            alu_q  <= alu_nxt;
            ctrl_q <= decode(state_nxt, cls_nxt, alu_nxt, bus.CON);
        end
    end

    assign bus.PCout        = ctrl_q.pc_out;
    assign bus.PCin         = ctrl_q.pc_in;
    assign bus.IncPC        = ctrl_q.inc_pc;
    assign bus.MARin        = ctrl_q.mar_in;
    assign bus.MDRin        = ctrl_q.mdr_in;
    assign bus.MDRout       = ctrl_q.mdr_out;
    assign bus.MDRread      = ctrl_q.mdr_read;
    assign bus.wren         = ctrl_q.wren;
    assign bus.IRin         = ctrl_q.ir_in;
    assign bus.Yin          = ctrl_q.y_in;
    assign bus.Zin          = ctrl_q.z_in;
    assign bus.ZLowout      = ctrl_q.zlow_out;
    assign bus.Gra          = ctrl_q.gra;
    assign bus.Grb          = ctrl_q.grb;
    assign bus.Grc          = ctrl_q.grc;
    assign bus.Rin          = ctrl_q.r_in;
    assign bus.Rout         = ctrl_q.r_out;
    assign bus.BAout        = ctrl_q.ba_out;
    assign bus.Cout         = ctrl_q.c_out;
    assign bus.CON_FF_In    = ctrl_q.con_ff_in;
    assign bus.ALUSelection = ctrl_q.alu_sel;
    assign bus.run          = ctrl_q.run;
endmodule
